dmem_responder: RTL

//  Data-memory responder serving the MEM stage's load/store requests over a

---
 rtl/dmem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: DEPTH x DW word array behind valid/ready request and
// response channels, fixed LATENCY, one request outstanding. Optional DMEM_BYTE_EN.
module dmem_responder #(
    parameter int DW      = 32,
    parameter int AW      = 7,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [31:0]   req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]    req_be_i,
`endif
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o
);

    // state  | meaning
    // S_IDLE | ready for a request, array access happens on accept
    // S_WAIT | latency timer running down
    // S_RESP | response presented until rsp_ready_i
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          oor;
    logic [AW-1:0] idx;

    assign accept = req_valid_i & req_ready_o;
    assign oor    = req_addr_i >= 32'(DEPTH);
    assign idx    = req_addr_i[AW-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(LATENCY - 1);
                    err_d   = oor;
                    rdata_d = (!req_we_i && !oor) ? mem[idx] : '0;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

    // Array is deliberately not reset; a store accepted before reset stays committed.
    always_ff @(posedge clk_i) begin
        if (accept && req_we_i && !oor) begin
`ifdef DMEM_BYTE_EN
            for (int i = 0; i < 4; i++) begin
                if (req_be_i[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
                end
            end
`else
            mem[idx] <= req_wdata_i;
`endif
        end
    end

endmodule
